// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - access-size and FSM types shared by the sized data memory
package data_memory_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane alignment of store data and extraction/extension of load data
//
// Ports:
//   lane          byte offset of the access within the memory word
//   size          access size (byte/half/word/double)
//   wdata         raw store data, right-aligned
//   is_unsigned   zero-extend load data instead of sign-extending
//   raw           full memory word read at the access index
//   byte_en       per-byte write enable for the store
//   wdata_shifted store data moved up to the lane offset
//   rdata_ext     load data right-aligned and extended to XLEN
module mem_lane_align
    import data_memory_pkg::*;
#(
    parameter  int XLEN   = 64,
    localparam int BYTES  = XLEN / 8,
    localparam int LANE_W = $clog2(BYTES)
) (
    input  logic [LANE_W-1:0] lane,
    input  size_e             size,
    input  logic [XLEN-1:0]   wdata,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   raw,
    output logic [BYTES-1:0]  byte_en,
    output logic [XLEN-1:0]   wdata_shifted,
    output logic [XLEN-1:0]   rdata_ext
);

    logic [3:0]       nbytes;
    logic [BYTES-1:0] low_mask;
    logic [XLEN-1:0]  shifted;
    logic             fill;

    assign nbytes = size_bytes(size);

    always_comb begin
        int nbits;
        low_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(nbytes)) begin
                low_mask[i] = 1'b1;
            end
        end
        byte_en       = low_mask << lane;
        wdata_shifted = wdata << {lane, 3'b000};
        shifted       = raw >> {lane, 3'b000};

        case (size)
            SZ_B:    fill = shifted[7];
            SZ_H:    fill = shifted[15];
            SZ_W:    fill = shifted[31];
            default: fill = shifted[XLEN-1];
        endcase
        fill = fill & ~is_unsigned;

        // A full-width access keeps every bit of the word, so the
        // extension fill (and with it is_unsigned) never applies.
        nbits = 8 * int'(nbytes);
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = (i < nbits) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressable data memory with sized loads/stores, faults, clear engine and debug taps
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only once the clear has finished)
//   req_write           1 = store, 0 = load
//   req_size            0 byte, 1 half, 2 word, 3 double
//   req_unsigned        zero-extend load data
//   req_addr, req_wdata byte address and right-aligned store data
//   rsp_valid           one-cycle response strobe, one cycle after acceptance
//   rsp_rdata           extended load data; 0 for stores and faults
//   rsp_fault           misaligned, out-of-range or illegal-size access
//   tap_data            NUM_TAPS full words starting at TAP_BASE
module data_memory_sized
    import data_memory_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 1024,
    parameter int NUM_TAPS    = 6,
    parameter int TAP_BASE    = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [XLEN-1:0]          req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     rsp_valid,
    output logic [XLEN-1:0]          rsp_rdata,
    output logic                     rsp_fault,
    output logic [NUM_TAPS*XLEN-1:0] tap_data
);

    localparam int BYTES  = XLEN / 8;
    localparam int WORDS  = DEPTH_BYTES / BYTES;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(WORDS);

    state_e            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [XLEN-1:0]   mem [WORDS];

    size_e             size;
    logic [3:0]        nbytes;
    logic [IDX_W-1:0]  word_idx;
    logic [LANE_W-1:0] lane;
    logic [XLEN:0]     end_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal_size;
    logic              fault;
    logic              accept;
    logic              do_write;
    logic [XLEN-1:0]   raw;
    logic [BYTES-1:0]  byte_en;
    logic [XLEN-1:0]   wdata_shifted;
    logic [XLEN-1:0]   rdata_ext;

    assign size      = size_e'(req_size);
    assign nbytes    = size_bytes(size);
    assign word_idx  = req_addr[LANE_W +: IDX_W];
    assign lane      = req_addr[LANE_W-1:0];
    assign req_ready = (state == ST_RUN);

    // Widened by one bit so an access near the top of the address space
    // cannot wrap around and slip past the range check.
    assign end_addr     = {1'b0, req_addr} + {{(XLEN-3){1'b0}}, nbytes};
    assign misaligned   = (req_addr[3:0] & (nbytes - 4'd1)) != 4'd0;
    assign out_of_range = end_addr > (XLEN+1)'(DEPTH_BYTES);
    assign illegal_size = (size == SZ_D) && (XLEN == 32);
    assign fault        = misaligned | out_of_range | illegal_size;

    assign accept   = req_valid & req_ready;
    assign do_write = accept & req_write & ~fault;
    assign raw      = mem[word_idx];

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .lane          (lane),
        .size          (size),
        .wdata         (req_wdata),
        .is_unsigned   (req_unsigned),
        .raw           (raw),
        .byte_en       (byte_en),
        .wdata_shifted (wdata_shifted),
        .rdata_ext     (rdata_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == IDX_W'(WORDS - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // The array has no reset of its own; the clear engine zero-fills it.
    // Since reset forces the FSM into CLEAR, a store arriving on a reset
    // edge is never accepted and never reaches the array.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_shifted[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_fault <= accept & fault;
            rsp_rdata <= (accept && !fault && !req_write) ? rdata_ext : '0;
        end
    end

    // Taps are blanked while clearing so stale contents never show
    // after a mid-run reset.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        localparam int TAP_ADDR = TAP_BASE + k * BYTES;
        if (TAP_ADDR + BYTES <= DEPTH_BYTES) begin : g_in
            assign tap_data[k*XLEN +: XLEN] =
                (state == ST_RUN) ? mem[IDX_W'(TAP_ADDR / BYTES)] : '0;
        end else begin : g_out
            assign tap_data[k*XLEN +: XLEN] = '0;
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - scoreboard testbench for data_memory_sized
module tb_data_memory_sized;

    localparam int XLEN     = 64;
    localparam int NUM_TAPS = 6;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [XLEN-1:0]          req_addr;
    logic [XLEN-1:0]          req_wdata;
    logic                     rsp_valid;
    logic [XLEN-1:0]          rsp_rdata;
    logic                     rsp_fault;
    logic [NUM_TAPS*XLEN-1:0] tap_data;

    typedef struct {
        string       name;
        logic        fault;
        logic [63:0] rdata;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    data_memory_sized #(
        .XLEN        (64),
        .DEPTH_BYTES (1024),
        .NUM_TAPS    (6),
        .TAP_BASE    (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .tap_data     (tap_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response must match the oldest expectation and arrive
    // exactly one cycle after its request.
    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 fault=%0b rdata=%h at cycle %0d, required no response",
                         rsp_fault, rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_fault !== e.fault || rsp_rdata !== e.rdata || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s: got fault=%0b rdata=%h cycle=%0d, required fault=%0b rdata=%h cycle=%0d",
                             e.name, rsp_fault, rsp_rdata, cyc, e.fault, e.rdata, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Drive one request for one cycle; inputs change #1 after the edge.
    task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d,
                         input logic ef, input logic [63:0] er);
        exp_t e;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        e.name  = name;
        e.fault = ef;
        e.rdata = er;
        e.due   = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);

        reset = 1'b0;
        wait_ready(n);
        check("clear_cycles", 64'(n), 64'd128);
        for (int k = 0; k < NUM_TAPS; k++) begin
            check($sformatf("tap%0d_after_clear", k), tap_data[k*64 +: 64], 64'd0);
        end

        issue("load_d_0",      1'b0, 2'd3, 1'b0, 64'd0,   64'd0, 1'b0, 64'd0);
        issue("store_d_256",   1'b1, 2'd3, 1'b0, 64'd256, 64'h8877665544332211, 1'b0, 64'd0);
        issue("load_b_263_s",  1'b0, 2'd0, 1'b0, 64'd263, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF88);
        issue("load_b_263_u",  1'b0, 2'd0, 1'b1, 64'd263, 64'd0, 1'b0, 64'h0000000000000088);
        idle(1);
        @(negedge clk);
        check("tap0_after_store", tap_data[0 +: 64], 64'h8877665544332211);

        @(posedge clk);
        #1;
        issue("store_h_258",   1'b1, 2'd1, 1'b0, 64'd258, 64'h000000000000BEEF, 1'b0, 64'd0);
        issue("load_d_256",    1'b0, 2'd3, 1'b0, 64'd256, 64'd0, 1'b0, 64'h88776655BEEF2211);
        issue("load_h_258_s",  1'b0, 2'd1, 1'b0, 64'd258, 64'd0, 1'b0, 64'hFFFFFFFFFFFFBEEF);
        issue("load_h_258_u",  1'b0, 2'd1, 1'b1, 64'd258, 64'd0, 1'b0, 64'h000000000000BEEF);

        issue("store_w_261_misal", 1'b1, 2'd2, 1'b0, 64'd261,  64'hDEADBEEF, 1'b1, 64'd0);
        issue("load_d_1020_range", 1'b0, 2'd3, 1'b0, 64'd1020, 64'd0, 1'b1, 64'd0);
        issue("load_h_257_misal",  1'b0, 2'd1, 1'b0, 64'd257,  64'd0, 1'b1, 64'd0);
        issue("load_d_256_again",  1'b0, 2'd3, 1'b0, 64'd256,  64'd0, 1'b0, 64'h88776655BEEF2211);
        issue("store_b_1023",      1'b1, 2'd0, 1'b0, 64'd1023, 64'h5A, 1'b0, 64'd0);
        issue("load_b_1023_u",     1'b0, 2'd0, 1'b1, 64'd1023, 64'd0, 1'b0, 64'h5A);
        issue("load_w_1020_s",     1'b0, 2'd2, 1'b0, 64'd1020, 64'd0, 1'b0, 64'h000000005A000000);
        issue("load_w_1024_range", 1'b0, 2'd2, 1'b0, 64'd1024, 64'd0, 1'b1, 64'd0);
        issue("store_w_280",       1'b1, 2'd2, 1'b0, 64'd280,  64'hFFFFFFFF80000001, 1'b0, 64'd0);
        issue("load_w_280_s",      1'b0, 2'd2, 1'b0, 64'd280,  64'd0, 1'b0, 64'hFFFFFFFF80000001);
        issue("load_w_280_u",      1'b0, 2'd2, 1'b1, 64'd280,  64'd0, 1'b0, 64'h0000000080000001);
        issue("load_d_280_u",      1'b0, 2'd3, 1'b1, 64'd280,  64'd0, 1'b0, 64'h0000000080000001);

        issue("b2b_store_d_264",   1'b1, 2'd3, 1'b0, 64'd264,  64'd5, 1'b0, 64'd0);
        issue("b2b_load_d_264",    1'b0, 2'd3, 1'b0, 64'd264,  64'd0, 1'b0, 64'd5);
        idle(2);
        @(negedge clk);
        check("tap1_after_store", tap_data[64 +: 64], 64'd5);
        check("tap2_before_reset", tap_data[128 +: 64], 64'd0);
        check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);

        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_addr     = 64'd272;
        req_wdata    = 64'h000000000000ABCD;
        reset        = 1'b1;
        @(negedge clk);
        check("midreset_req_ready", 64'(req_ready), 64'd0);
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_tap0_blank", tap_data[0 +: 64], 64'd0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n);
        check("reclear_cycles", 64'(n), 64'd128);
        check("tap2_after_reclear", tap_data[128 +: 64], 64'd0);
        check("tap1_after_reclear", tap_data[64 +: 64], 64'd0);
        check("tap0_after_reclear", tap_data[0 +: 64], 64'd0);

        issue("load_d_272_reclear", 1'b0, 2'd3, 1'b0, 64'd272, 64'd0, 1'b0, 64'd0);
        idle(3);
        @(negedge clk);
        check("queue_drained_at_end", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised, byte-addressable data memory for the RISC-V datapath, replacing the fixed 64-bit-only data memory. It supports byte, half, word and double accesses, with sign or zero extension on loads, and registers every response behind a valid handshake. It flags misaligned and out-of-range accesses as faults, zero-fills itself after reset with a clear engine, and exposes a configurable bank of full-width debug taps for the sort-result display.

## Interface
- XLEN, 64: data and address width (32 or 64).
- DEPTH_BYTES, 1024: memory size in bytes; must be a power of two and a multiple of XLEN/8.
- NUM_TAPS, 6: number of debug tap words.
- TAP_BASE, 256: byte address of tap 0; must be XLEN/8 aligned.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend load data (LBU/LHU/LWU).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low 8·2^size bits are used.
- rsp_valid  out  1  response present for exactly one cycle.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access was misaligned, out of range, or had an illegal size.
- tap_data  out  NUM_TAPS·XLEN  tap k = little-endian word at TAP_BASE + k·XLEN/8.

## Operation
- Storage: DEPTH_BYTES/(XLEN/8) words of XLEN bits, written per byte lane. Word index = addr / (XLEN/8); lane = addr mod (XLEN/8).
- FSM states:
  - CLEAR: entered on reset. A counter walks every word index and writes 0. req_ready = 0. Moves to RUN after the last index.
  - RUN: req_ready = 1 continuously.
- A request is accepted on any edge where req_valid && req_ready. Only one request per cycle.
- Fault checks, any of which sets the fault:
  - addr mod 2^size ≠ 0 (misaligned);
  - addr + 2^size > DEPTH_BYTES (out of range);
  - size = 3 with XLEN = 32 (illegal size).
- On a fault: no write occurs, rsp_fault = 1, rsp_rdata = 0.
- Store: the low 2^size bytes of req_wdata are written to lanes starting at the lane offset. All other bytes are unchanged.
- Load: the selected 2^size bytes are right-aligned, then sign-extended from the top bit unless req_unsigned is set. A load of the full XLEN ignores req_unsigned.
- tap_data is combinational from the array. It reads 0 during and after CLEAR until overwritten. Taps outside DEPTH_BYTES read 0.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0. The clear counter is 0 and the FSM is in CLEAR.
- Clear takes exactly DEPTH_BYTES/(XLEN/8) cycles after reset deasserts. req_ready rises on the following edge: 128 cycles for the defaults.
- Latency: a request accepted at edge n produces rsp_valid = 1 from edge n+1 until edge n+2 unless another request is accepted at edge n+1. Full throughput is one request per cycle.
- A store accepted at edge n is visible to a load accepted at edge n+1 and to tap_data after edge n.
- Reset asserted mid-operation:
  - rsp_valid, rsp_fault and rsp_rdata go to 0 immediately.
  - A store coinciding with the reset edge is not written.
  - CLEAR restarts from index 0.
- rsp_valid has no back-pressure. The consumer must take the response in its valid cycle.

## Structure
- Package data_memory_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum (ST_CLEAR, ST_RUN);
  - a function for bytes-per-size.
- Sub-module mem_lane_align is combinational. It takes addr lane, size, wdata and unsigned, and produces:
  - the byte-enable mask;
  - the lane-shifted store data;
  - the extracted and extended load data from a raw read word.
- Top level holds the array, the clear FSM/counter, the fault checks and the response registers.

## Test plan
- Release reset and count cycles until req_ready rises → 128 cycles; all taps and a load of addr 0 return 0.
- Store double 0x8877665544332211 at addr 256, then load byte addr 263 signed → 0xFFFFFFFFFFFFFF88; unsigned → 0x88; tap 0 = 0x8877665544332211.
- Store half 0xBEEF at addr 258 → word at 256 reads 0x88776655BEEF2211; load half 258 signed → 0xFFFFFFFFFFFFBEEF.
- Store word at addr 261 or load double at addr 1020 → rsp_fault = 1, rsp_rdata = 0, memory unchanged.
- Back-to-back: store double 5 at 264 then load double 264 on the next cycle → rsp_valid on two consecutive cycles; the second returns 5; tap 1 = 5.
- Assert reset on the same edge as a store to 272 → after CLEAR, tap 2 = 0 and rsp_valid stayed 0 throughout.
